counter_driver: RTL and testbench
=================================

COUNTER_DRIVER -- requirements
Module: counter_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4, setting the width of the counter data path (D, Q, CMD_DATA).
REQ-002 SHALL have parameter LEN_W, default 8, setting the width of CMD_LEN and RCO_CNT.
REQ-003 CLK  input  1  single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  reset, synchronous and active-high.
REQ-005 CMD_VALID  input  1  command request.
REQ-006 CMD_READY  output  1  driver can accept a command.
REQ-007 CMD_MODE  input  2  mode to drive on MODO for this command.
REQ-008 CMD_DATA  input  WIDTH  value to drive on D for this command.
REQ-009 CMD_LEN  input  LEN_W  number of cycles ENABLE is held high.
REQ-010 ENABLE  output  1  counter enable.
REQ-011 MODO  output  2  counter mode select.
REQ-012 D  output  WIDTH  counter load data.
REQ-013 Q  input  WIDTH  counter value returned by the counter.
REQ-014 RCO  input  1  counter ripple-carry-out.
REQ-015 LOAD  input  1  counter load indication.
REQ-016 BUSY  output  1  high in every state except IDLE.
REQ-017 DONE  output  1  one-cycle pulse when a command completes.
REQ-018 RCO_CNT  output  LEN_W  RCO-high cycles seen during the last command.
REQ-019 LOAD_ERR  output  1  a LOAD/Q mismatch occurred during the last command.

Function
REQ-020 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN and REPORT.
REQ-021 In IDLE, CMD_READY SHALL be 1, and CMD_READY SHALL be 0 in all other states.
REQ-022 A command SHALL be accepted on a rising edge where CMD_VALID=1 and CMD_READY=1; CMD_MODE, CMD_DATA and CMD_LEN SHALL be latched on that edge.
REQ-023 On acceptance, the FSM SHALL go IDLE->RUN if CMD_LEN!=0, else IDLE->REPORT.
REQ-024 On acceptance, RCO_CNT SHALL clear to 0 and LOAD_ERR SHALL clear to 0.
REQ-025 In RUN: ENABLE=1, MODO=latched mode, D=latched data, and a remaining-cycle counter decrements once per cycle.
REQ-026 RUN SHALL transition to DRAIN on the edge where the remaining-cycle counter equals 1.
REQ-027 ENABLE SHALL be high for exactly CMD_LEN consecutive cycles (accepted at edge k -> high in cycles k+1..k+CMD_LEN).
REQ-028 DRAIN SHALL last exactly one cycle with ENABLE=0 and MODO/D held at their latched values, then go to REPORT.
REQ-029 REPORT SHALL last exactly one cycle with DONE=1, then go to IDLE.
REQ-030 DONE SHALL be high only in REPORT.
REQ-031 Completion latency: DONE in cycle k+CMD_LEN+2 for CMD_LEN>0, and in cycle k+1 for CMD_LEN=0.
REQ-032 Outside RUN and DRAIN, ENABLE SHALL be 0.
REQ-033 In IDLE, MODO and D SHALL hold their last driven values.
REQ-034 RCO_CNT SHALL increment on every RUN or DRAIN cycle with RCO=1, saturating at 2^LEN_W-1 (no wrap).
REQ-035 In any RUN or DRAIN cycle with LOAD=1 and Q != latched data, LOAD_ERR SHALL set and stay set (sticky) until the next acceptance.
REQ-036 RCO and LOAD SHALL be ignored in IDLE and REPORT.
REQ-037 RCO_CNT and LOAD_ERR SHALL remain stable from REPORT until the next command is accepted.
REQ-038 CMD_VALID held high in REPORT SHALL NOT be accepted until the following IDLE cycle, giving a minimum of one idle cycle between commands.

Reset
REQ-039 With RESET=1 at a rising edge, the FSM SHALL enter IDLE, from any state including mid-RUN.
REQ-040 Reset values: ENABLE=0, MODO=2'b00, D=0, DONE=0, BUSY=0, RCO_CNT=0, LOAD_ERR=0, CMD_READY=1 after the reset edge.
REQ-041 A reset during RUN SHALL drop ENABLE on that same edge and SHALL NOT produce DONE.
REQ-042 CMD_VALID SHALL be ignored in any cycle where RESET=1.

Verification
REQ-043 LEN=5, MODE=00, DATA=0, accepted at edge k -> ENABLE high in cycles k+1..k+5, DONE in cycle k+7, BUSY high in k+1..k+7.
REQ-044 LEN=20, mode 00, counter starting at Q=0 (WIDTH=4) -> exactly one RCO cycle is seen, and RCO_CNT=1 at DONE.
REQ-045 MODE=11, DATA=4'hA, LEN=2, correct counter -> LOAD_ERR=0; same stimulus with Q forced to 4'h3 while LOAD=1 -> LOAD_ERR=1.
REQ-046 LEN=0 -> ENABLE stays 0 throughout, DONE in cycle k+1, RCO_CNT=0.
REQ-047 RESET asserted in the 3rd RUN cycle of a LEN=10 command -> ENABLE=0 and CMD_READY=1 after that edge, and DONE never pulses.
REQ-048 LEN_W=8, LEN=255, RCO forced to 1 -> RCO_CNT saturates at 255 and does not wrap.

Source files
------------

// File: rtl/counter_driver.sv
// Command-driven sequencer for an external up/down counter: drives ENABLE/MODO/D
// for CMD_LEN cycles, then reports RCO activity and load-value mismatches.
module counter_driver #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             CMD_VALID,
  output logic             CMD_READY,
  input  logic [1:0]       CMD_MODE,
  input  logic [WIDTH-1:0] CMD_DATA,
  input  logic [LEN_W-1:0] CMD_LEN,
  output logic             ENABLE,
  output logic [1:0]       MODO,
  output logic [WIDTH-1:0] D,
  input  logic [WIDTH-1:0] Q,
  input  logic             RCO,
  input  logic             LOAD,
  output logic             BUSY,
  output logic             DONE,
  output logic [LEN_W-1:0] RCO_CNT,
  output logic             LOAD_ERR
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

  state_t           state_q, state_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [1:0]       mode_d;
  logic [WIDTH-1:0] data_d;
  logic [LEN_W-1:0] rco_cnt_d;
  logic             load_err_d;
  logic             active;

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state, latched command fields and monitor accumulation
  always_comb begin
    state_d    = state_q;
    rem_d      = rem_q;
    mode_d     = MODO;
    data_d     = D;
    rco_cnt_d  = RCO_CNT;
    load_err_d = LOAD_ERR;
    active     = (state_q == RUN) || (state_q == DRAIN);

    if (active) begin
      if (RCO && (RCO_CNT != '1)) rco_cnt_d = RCO_CNT + LEN_W'(1);
      if (LOAD && (Q != D))       load_err_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (CMD_VALID) begin
          mode_d     = CMD_MODE;
          data_d     = CMD_DATA;
          rem_d      = CMD_LEN;
          rco_cnt_d  = '0;
          load_err_d = 1'b0;
          state_d    = (CMD_LEN != '0) ? RUN : REPORT;
        end
      end
      RUN: begin
        rem_d = rem_q - LEN_W'(1);
        if (rem_q == LEN_W'(1)) state_d = DRAIN;
      end
      DRAIN:   state_d = REPORT;
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge CLK) begin
    if (RESET) begin
      rem_q     <= '0;
      CMD_READY <= 1'b1;
      ENABLE    <= 1'b0;
      MODO      <= 2'b00;
      D         <= '0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      RCO_CNT   <= '0;
      LOAD_ERR  <= 1'b0;
    end else begin
      rem_q     <= rem_d;
      CMD_READY <= (state_d == IDLE);
      ENABLE    <= (state_d == RUN);
      MODO      <= mode_d;
      D         <= data_d;
      BUSY      <= (state_d != IDLE);
      DONE      <= (state_d == REPORT);
      RCO_CNT   <= rco_cnt_d;
      LOAD_ERR  <= load_err_d;
    end
  end

endmodule

// File: tb/tb_counter_driver.sv
// Bench for counter_driver: per-command timeline model (enable window, done cycle,
// RCO count, load-mismatch flag) checked cycle by cycle against the DUT.
module tb_counter_driver;
  localparam int unsigned WIDTH = 4;
  localparam int unsigned LEN_W = 8;
  localparam int          RCO_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             reset, cmd_valid, cmd_ready;
  logic [1:0]       cmd_mode, modo;
  logic [WIDTH-1:0] cmd_data, d, q;
  logic [LEN_W-1:0] cmd_len, rco_cnt;
  logic             enable, rco, load, busy, done, load_err;

  int n_tests = 0;
  int n_fail  = 0;
  int emu_q   = 0;

  always #5 clk = ~clk;

  counter_driver #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .CLK(clk), .RESET(reset), .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready),
    .CMD_MODE(cmd_mode), .CMD_DATA(cmd_data), .CMD_LEN(cmd_len),
    .ENABLE(enable), .MODO(modo), .D(d), .Q(q), .RCO(rco), .LOAD(load),
    .BUSY(busy), .DONE(done), .RCO_CNT(rco_cnt), .LOAD_ERR(load_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Side inputs from the counter: 0 random, 1 emulated counter, 2 RCO stuck high,
  // 3 LOAD with matching Q, 4 LOAD with Q stuck at 3
  task automatic drive_side(input int smode, input logic [WIDTH-1:0] data);
    case (smode)
      1: begin q = WIDTH'(emu_q); rco = (emu_q == 15); load = 1'b0; end
      2: begin q = WIDTH'($urandom); rco = 1'b1; load = 1'b0; end
      3: begin q = data; rco = 1'b0; load = 1'b1; end
      4: begin q = 4'h3; rco = 1'b0; load = 1'b1; end
      default: begin
        rco  = 1'($urandom % 2);
        load = ($urandom % 4) == 0;
        q    = ($urandom % 2 == 0) ? data : WIDTH'($urandom);
      end
    endcase
  endtask

  task automatic run_cmd(input logic [1:0] mode, input logic [WIDTH-1:0] data, input int len,
                         input int smode, input int exp_rco, input int exp_err);
    int done_c;
    int m_rco;
    bit m_err;
    bit act;
    done_c = (len == 0) ? 1 : len + 2;
    m_rco  = 0;
    m_err  = 1'b0;
    emu_q  = 0;
    check("ready_before_cmd", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_mode = mode; cmd_data = data; cmd_len = LEN_W'(len);
    drive_side(smode, data);
    @(posedge clk); #1;
    for (int c = 1; c <= done_c; c++) begin
      act = (len > 0) && (c <= len + 1);
      check("enable", 32'(enable), 32'(c <= len));
      check("done",   32'(done),   32'(c == done_c));
      check("busy",   32'(busy),   32'd1);
      check("ready",  32'(cmd_ready), 32'd0);
      if (act) begin
        check("modo", 32'(modo), 32'(mode));
        check("d",    32'(d),    32'(data));
      end
      if (c == done_c) begin
        check("rco_cnt",  32'(rco_cnt),  32'(m_rco));
        check("load_err", 32'(load_err), 32'(m_err));
        if (exp_rco >= 0) check("rco_cnt_directed",  32'(rco_cnt),  32'(exp_rco));
        if (exp_err >= 0) check("load_err_directed", 32'(load_err), 32'(exp_err));
      end
      // junk command while busy must never be taken
      cmd_valid = 1'($urandom % 2);
      cmd_mode  = 2'($urandom);
      cmd_data  = WIDTH'($urandom);
      cmd_len   = LEN_W'($urandom);
      drive_side(smode, data);
      if (act) begin
        if (rco && m_rco < RCO_MAX) m_rco++;
        if (load && q != data) m_err = 1'b1;
      end
      @(posedge clk); #1;
      if (smode == 1 && c <= len) emu_q = (emu_q + 1) % 16;
    end
    for (int i = 0; i < 2; i++) begin
      check("idle_ready",    32'(cmd_ready), 32'd1);
      check("idle_busy",     32'(busy),      32'd0);
      check("idle_done",     32'(done),      32'd0);
      check("idle_enable",   32'(enable),    32'd0);
      check("hold_rco_cnt",  32'(rco_cnt),   32'(m_rco));
      check("hold_load_err", 32'(load_err),  32'(m_err));
      cmd_valid = 1'b0;
      drive_side(0, data);
      if (i == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_enable"},   32'(enable),    32'd0);
    check({tag, "_modo"},     32'(modo),      32'd0);
    check({tag, "_d"},        32'(d),         32'd0);
    check({tag, "_done"},     32'(done),      32'd0);
    check({tag, "_busy"},     32'(busy),      32'd0);
    check({tag, "_rco_cnt"},  32'(rco_cnt),   32'd0);
    check({tag, "_load_err"}, 32'(load_err),  32'd0);
    check({tag, "_ready"},    32'(cmd_ready), 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b1; cmd_mode = 2'b11; cmd_data = 4'hF; cmd_len = 8'd3;
    q = '0; rco = 1'b1; load = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset = 1'b0; cmd_valid = 1'b0;
    @(posedge clk); #1;

    run_cmd(2'b00, 4'h0, 5,   0, -1, -1);
    run_cmd(2'b00, 4'h0, 20,  1,  1, -1);
    run_cmd(2'b11, 4'hA, 2,   3, -1,  0);
    run_cmd(2'b11, 4'hA, 2,   4, -1,  1);
    run_cmd(2'b01, 4'h5, 0,   2,  0,  0);
    run_cmd(2'b10, 4'h7, 1,   0, -1, -1);
    run_cmd(2'b00, 4'h0, 255, 2, 255, -1);
    for (int i = 0; i < 20; i++)
      run_cmd(2'($urandom), WIDTH'($urandom), int'($urandom_range(0, 12)), 0, -1, -1);

    // reset in the 3rd RUN cycle of a LEN=10 command
    cmd_valid = 1'b1; cmd_mode = 2'b10; cmd_data = 4'h9; cmd_len = 8'd10;
    rco = 1'b1; load = 1'b1; q = 4'h1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check("run1_enable", 32'(enable), 32'd1);
    repeat (2) begin @(posedge clk); #1; end
    check("run3_enable", 32'(enable), 32'd1);
    reset = 1'b1; cmd_valid = 1'b1;
    @(posedge clk); #1;
    check_reset_state("midrun_reset");
    reset = 1'b0; cmd_valid = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", 32'(done), 32'd0);
    end

    // the DUT must still accept work afterwards
    run_cmd(2'b01, 4'hC, 3, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
